// File: rtl/synth_pkg.sv
// Shared types and defaults for the tone selection slice.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned NUM_KEYS_DEFAULT        = 8;
  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;

endpackage

// File: rtl/key_debouncer.sv
// Single key conditioner: 2-flop synchronizer followed by a stable-count debouncer.
module key_debouncer
  import synth_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new key level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      key_clean <= 1'b0;
    end else if (sync_b == key_clean) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt       <= '0;
      key_clean <= ~key_clean;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tone_selector.sv
// Debounces a key bank, picks the lowest pressed key and routes its tone to
// audio_out, never cutting short a high pulse of the outgoing tone.
module tone_selector
  import synth_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned IDX_W           = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic [NUM_KEYS-1:0] tones_in,
  output logic [NUM_KEYS-1:0] keys_clean,
  output logic                audio_out,
  output logic                note_active,
  output logic [IDX_W-1:0]    note_index
);

  state_t           state, state_next;
  logic [IDX_W-1:0] cur, cur_next;
  logic             audio_next;
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             tone_cur;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (keys_raw[g]),
      .key_clean(keys_clean[g])
    );
  end

  // Lowest-index pressed key wins; chords resolve downward.
  always_comb begin
    req_valid = 1'b0;
    req_idx   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (keys_clean[i] && !req_valid) begin
        req_valid = 1'b1;
        req_idx   = IDX_W'(i);
      end
    end
  end

  // State, latched note and registered audio.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_next;
      cur       <= cur_next;
      audio_out <= audio_next;
    end
  end

  // Next-state, note latch and audio selection; DRAIN only releases on a low tone sample.
  always_comb begin
    state_next  = state;
    cur_next    = cur;
    audio_next  = 1'b0;
    tone_cur    = tones_in[cur];
    note_active = (state != IDLE);
    note_index  = (state == IDLE) ? '0 : cur;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cur_next   = req_idx;
          state_next = PLAY;
        end
      end
      PLAY: begin
        audio_next = tone_cur;
        if (!req_valid || (req_idx != cur)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!tone_cur) begin
          if (req_valid) begin
            cur_next   = req_idx;
            state_next = PLAY;
          end else begin
            state_next = IDLE;
          end
        end else begin
          audio_next = 1'b1;
          if (req_valid && (req_idx == cur)) begin
            state_next = PLAY;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tone_selector.sv
// Self-checking bench for tone_selector with DEBOUNCE_CYCLES=4, NUM_KEYS=8.
module tb_tone_selector;

  localparam int NK  = 8;
  localparam int DB  = 4;
  localparam int IW  = 3;
  localparam int LAT = 2 + DB;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] tones_in;
  logic [NK-1:0] keys_clean;
  logic          audio_out;
  logic          note_active;
  logic [IW-1:0] note_index;

  tone_selector #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys_raw   (keys_raw),
    .tones_in   (tones_in),
    .keys_clean (keys_clean),
    .audio_out  (audio_out),
    .note_active(note_active),
    .note_index (note_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Tone generator state: tone i toggles every 3+i cycles.
  int tcnt[NK];

  // Reference model: raw key history, run lengths, accepted levels, sounding note.
  logic [NK-1:0] m_raw_d1, m_raw_d2, m_clean;
  int            m_run[NK];
  bit            m_sounding, m_draining, m_audio;
  int            m_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_raw_d1 = '0; m_raw_d2 = '0; m_clean = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    m_sounding = 0; m_draining = 0; m_audio = 0; m_cur = 0;
  endtask

  // One clock edge of the model, using the inputs present just before the edge.
  task automatic model_edge();
    bit rv;
    int ri;
    bit tone;
    rv = 0; ri = 0;
    for (int i = NK - 1; i >= 0; i--) if (m_clean[i]) begin rv = 1; ri = i; end
    tone = tones_in[m_cur];
    if (!m_sounding) begin
      m_audio = 0;
      if (rv) begin m_cur = ri; m_sounding = 1; m_draining = 0; end
    end else if (!m_draining) begin
      m_audio = tone;
      if (!rv || ri != m_cur) m_draining = 1;
    end else if (!tone) begin
      m_audio = 0;
      if (rv) begin m_cur = ri; m_draining = 0; end
      else m_sounding = 0;
    end else begin
      m_audio = 1;
      if (rv && ri == m_cur) m_draining = 0;
    end
    for (int i = 0; i < NK; i++) begin
      if (m_raw_d2[i] != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_clean[i] = ~m_clean[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_raw_d2 = m_raw_d1;
    m_raw_d1 = keys_raw;
  endtask

  task automatic advance_tones();
    for (int i = 0; i < NK; i++) begin
      tcnt[i]++;
      if (tcnt[i] == 3 + i) begin tcnt[i] = 0; tones_in[i] = ~tones_in[i]; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("keys_clean", 32'(keys_clean), 32'(m_clean));
    check("audio_out", 32'(audio_out), 32'(m_audio));
    check("note_active", 32'(note_active), 32'(m_sounding));
    check("note_index", 32'(note_index), m_sounding ? 32'(m_cur) : 32'd0);
    advance_tones();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_clean(input int k, input logic val, output int lat);
    lat = 0;
    do begin tick(); lat++; end while (keys_clean[k] !== val && lat < 60);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_sounding && n < 100) begin tick(); n++; end
    check(tag, 32'(note_active), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    reset    = 1'b1;
    keys_raw = '0;
    tones_in = '0;
    for (int i = 0; i < NK; i++) tcnt[i] = 0;
    model_reset();
    #8;
    check("rst_keys_clean", 32'(keys_clean), 32'd0);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_active", 32'(note_active), 32'd0);
    check("rst_index", 32'(note_index), 32'd0);
    #4 reset = 1'b0;
    ticks(3);

    // Clean press of key 2.
    keys_raw[2] = 1'b1;
    wait_clean(2, 1'b1, lat);
    check("key2_latency", 32'(lat), 32'(LAT));
    ticks(30);
    check("key2_index", 32'(note_index), 32'd2);
    keys_raw[2] = 1'b0;
    wait_idle("key2_release_idle");
    ticks(3);

    // Bouncy press of key 5.
    keys_raw[5] = 1'b1; ticks(2);
    keys_raw[5] = 1'b0; ticks(2);
    keys_raw[5] = 1'b1;
    wait_clean(5, 1'b1, lat);
    check("key5_latency", 32'(lat), 32'(LAT));
    ticks(20);
    keys_raw[5] = 1'b0;
    wait_idle("key5_release_idle");
    ticks(2);

    // Chord of keys 6 and 3, then release 3 while its tone is high.
    keys_raw[6] = 1'b1; keys_raw[3] = 1'b1;
    ticks(20);
    check("chord_index", 32'(note_index), 32'd3);
    n = 0;
    while (tones_in[3] !== 1'b1 && n < 20) begin tick(); n++; end
    keys_raw[3] = 1'b0;
    ticks(30);
    check("chord_after_release", 32'(note_index), 32'd6);

    // Async reset while tone 6 is audible.
    n = 0;
    while (audio_out !== 1'b1 && n < 40) begin tick(); n++; end
    check("pre_reset_audio", 32'(audio_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_audio", 32'(audio_out), 32'd0);
    check("async_active", 32'(note_active), 32'd0);
    check("async_keys", 32'(keys_clean), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    advance_tones();
    wait_clean(6, 1'b1, lat);
    check("post_reset_latency", 32'(lat), 32'(LAT));
    ticks(4);

    // Brief release of key 6 timed so the re-press lands inside DRAIN.
    n = 0;
    while (!(tones_in[6] == 1'b0 && tcnt[6] == 5) && n < 40) begin tick(); n++; end
    keys_raw[6] = 1'b0; ticks(4);
    keys_raw[6] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("redrain_active", 32'(note_active), 32'd1);
      check("redrain_index", 32'(note_index), 32'd6);
    end

    // Release the only key; expect a drain then idle outputs.
    keys_raw[6] = 1'b0;
    wait_idle("release_only_idle");
    tick();
    check("idle_audio", 32'(audio_out), 32'd0);
    check("idle_index", 32'(note_index), 32'd0);

    // Randomized key activity including bounces.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) keys_raw[$urandom_range(NK - 1)] ^= 1'b1;
      tick();
    end
    keys_raw = '0;
    wait_idle("random_final_idle");
    ticks(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
